// File: rtl/local_history_bp.sv
// Two-level local-history branch predictor: per-branch history selects a
// 2-bit saturating counter; reports the miss combinationally and trains each clock.
module local_history_bp #(
    parameter int ID_W   = 3,
    parameter int HIST_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ID_W-1:0]  branchID,
    input  logic             outcome,
    output logic             miss,
    output logic             prediction,
    output logic [CNT_W-1:0] miss_count
);

    localparam int N_BR  = 1 << ID_W;
    localparam int IDX_W = ID_W + HIST_W;
    localparam int N_PHT = 1 << IDX_W;

    logic [HIST_W-1:0] bht_q [N_BR];
    logic [HIST_W-1:0] bht_d [N_BR];
    logic [1:0]        pht_q [N_PHT];
    logic [1:0]        pht_d [N_PHT];
    logic [CNT_W-1:0]  miss_count_q;
    logic [CNT_W-1:0]  miss_count_d;

    logic [HIST_W-1:0] hist;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        ctr;
    logic [HIST_W:0]   hist_shift;

    assign hist = bht_q[branchID];
    assign idx  = {branchID, hist};
    assign ctr  = pht_q[idx];

    assign prediction = ctr[1] & ~reset;
    assign miss       = (prediction ^ outcome) & ~reset;
    assign miss_count = miss_count_q;

    // Dropping the MSB of {hist, outcome} keeps the newest HIST_W outcomes,
    // which also covers the single-bit history case.
    assign hist_shift = {hist, outcome};

    always_comb begin
        bht_d        = bht_q;
        pht_d        = pht_q;
        miss_count_d = miss_count_q;

        bht_d[branchID] = hist_shift[HIST_W-1:0];

        if (outcome) begin
            if (ctr != 2'b11) begin
                pht_d[idx] = ctr + 2'b01;
            end
        end else begin
            if (ctr != 2'b00) begin
                pht_d[idx] = ctr - 2'b01;
            end
        end

        if (miss && (miss_count_q != {CNT_W{1'b1}})) begin
            miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BR; i++) begin
                bht_q[i] <= '0;
            end
            for (int j = 0; j < N_PHT; j++) begin
                pht_q[j] <= 2'b01;
            end
            miss_count_q <= '0;
        end else begin
            bht_q        <= bht_d;
            pht_q        <= pht_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_local_history_bp.sv
// Directed and randomized checks of local_history_bp against a
// behavioural model of per-branch histories and 2-bit counters.
module tb_local_history_bp;

    localparam int ID_W   = 3;
    localparam int HIST_W = 2;
    localparam int CNT_W  = 4;
    localparam int N_BR   = 1 << ID_W;
    localparam int N_HIST = 1 << HIST_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [ID_W-1:0]  branchID;
    logic             outcome;
    logic             miss;
    logic             prediction;
    logic [CNT_W-1:0] miss_count;

    int checks = 0;
    int passes = 0;

    // reference state: history as an integer of recent outcomes,
    // counters as integers 0..3, miss total clipped at CMAX
    int m_hist [N_BR];
    int m_ctr  [N_BR*N_HIST];
    int m_miss;
    int last_miss;

    local_history_bp #(
        .ID_W  (ID_W),
        .HIST_W(HIST_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .branchID  (branchID),
        .outcome   (outcome),
        .miss      (miss),
        .prediction(prediction),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_BR; i++) m_hist[i] = 0;
        for (int i = 0; i < N_BR*N_HIST; i++) m_ctr[i] = 1;
        m_miss = 0;
    endtask

    // One clock: drive, check outputs at negedge, then advance the model
    task automatic cyc(input bit rst, input int id, input bit o);
        int slot, exp_pred, exp_miss;
        @(posedge clk);
        #1;
        reset    = rst;
        branchID = ID_W'(id);
        outcome  = o;
        @(negedge clk);
        slot     = id * N_HIST + m_hist[id];
        exp_pred = rst ? 0 : (m_ctr[slot] >= 2 ? 1 : 0);
        exp_miss = rst ? 0 : (exp_pred != int'(o) ? 1 : 0);
        check("prediction", int'(prediction), exp_pred);
        check("miss", int'(miss), exp_miss);
        check("miss_count", int'(miss_count), m_miss);
        last_miss = int'(miss);
        if (rst) begin
            model_reset();
        end else begin
            if (o) m_ctr[slot] = (m_ctr[slot] < 3) ? m_ctr[slot] + 1 : 3;
            else   m_ctr[slot] = (m_ctr[slot] > 0) ? m_ctr[slot] - 1 : 0;
            m_hist[id] = (m_hist[id] * 2 + int'(o)) % N_HIST;
            if (exp_miss == 1 && m_miss < CMAX) m_miss++;
        end
    endtask

    initial begin
        int taken_pat [6] = '{1, 1, 1, 0, 0, 0};
        int alt_pat  [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

        reset    = 1'b1;
        branchID = '0;
        outcome  = 1'b0;
        model_reset();

        cyc(1, 0, 0);
        cyc(1, 0, 1);

        // cold start
        cyc(0, 0, 1);
        check("cold_miss", last_miss, 1);
        cyc(0, 7, 0);
        check("cold_count", int'(miss_count), 1);

        // always-taken branch 3
        for (int k = 0; k < 6; k++) begin
            cyc(0, 3, 1);
            check($sformatf("taken_miss%0d", k), last_miss, taken_pat[k]);
        end

        // alternating branch 5
        for (int k = 0; k < 10; k++) begin
            cyc(0, 5, (k % 2) == 0);
            check($sformatf("alt_miss%0d", k), last_miss, alt_pat[k]);
        end

        // isolation: fresh branch 4, then branch 3 still predicts taken
        cyc(0, 4, 1);
        check("iso_miss4", last_miss, 1);
        cyc(0, 3, 1);
        check("iso_hit3", last_miss, 0);

        // reset mid-stream wipes training
        cyc(1, 3, 1);
        check("rst_miss", last_miss, 0);
        cyc(0, 3, 1);
        check("rst_count", int'(miss_count), 0);
        check("rst_retrain", last_miss, 1);

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 39) == 0,
                $urandom_range(0, N_BR - 1),
                $urandom_range(0, 3) != 0);
        end

        // saturation: 24 first visits of fresh indices, all taken
        cyc(1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < N_BR; b++) begin
                cyc(0, b, 1);
            end
        end
        cyc(0, 0, 0);
        check("sat_count", int'(miss_count), CMAX);
        cyc(0, 0, 0);
        check("sat_hold", int'(miss_count), CMAX);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
